// File: rtl/pipeline_types.sv
// Shared fetch-pipeline types: icache geometry and responder FSM states.
// Tag/index/offset split of a 32-bit fetch address lives here too.
package pipeline_types;

  localparam int ICACHE_INDEX_W    = 8;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_OFFSET_W   = 4;
  localparam int ICACHE_TAG_W      =
    32 - ICACHE_INDEX_W - ICACHE_OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    REFILL,
    RESP
  } icache_state_t;

endpackage

// File: rtl/icache_data_ram.sv
// Icache data array: one word-write port for refill beats,
// one whole-line read port indexed by set.
module icache_data_ram #(
  parameter int INDEX_W    = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [INDEX_W-1:0]           wr_index,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                  wr_data,
  input  logic [INDEX_W-1:0]           rd_index,
  output logic [LINE_WORDS*32-1:0]     rd_line
);

  logic [LINE_WORDS*32-1:0] mem [1 << INDEX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_index][wr_word*32 +: 32] <= wr_data;
    end
  end

  assign rd_line = mem[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder: lookup, line refill,
// flush/invalidate handling; returns an instruction pair per request.
module icache_responder
  import pipeline_types::*;
#(
  parameter int INDEX_W    = ICACHE_INDEX_W,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [31:0]        req_pc,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [63:0]        rsp_inst,
  output logic [31:0]        rsp_pc,
  input  logic               branch_flush,
  input  logic               cop_valid,
  input  logic [INDEX_W-1:0] cop_index,
  output logic               cop_ready,
  output logic               rd_req,
  output logic [31:0]        rd_addr,
  input  logic               rd_rdy,
  input  logic               ret_valid,
  input  logic               ret_last,
  input  logic [31:0]        ret_data
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int TAG_W  = 32 - INDEX_W - OFF_W;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int SETS   = 1 << INDEX_W;

  icache_state_t state_q, state_d;

  logic [31:0]         pc_q;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q [SETS];
  logic [BEAT_W-1:0]   beat_q;
  logic                drop_q;
  logic [LINE_WORDS*32-1:0] line;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [OFF_W-4:0]    pair;
  logic                hit;
  logic                accept;
  logic                beat_fire;
  logic                fill_done;

  assign idx       = pc_q[OFF_W +: INDEX_W];
  assign pc_tag    = pc_q[31 -: TAG_W];
  assign pair      = pc_q[OFF_W-1:3];
  assign hit       = valid_q[idx] && (tag_q[idx] == pc_tag);
  assign accept    = req_valid && req_ready;
  assign beat_fire = (state_q == REFILL) && ret_valid;
  assign fill_done = beat_fire && ret_last;

  assign rd_addr  = {pc_q[31:OFF_W], {OFF_W{1'b0}}};
  assign rsp_pc   = pc_q;
  assign rsp_inst = line[pair*64 +: 64];

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    cop_ready = 1'b0;
    rsp_valid = 1'b0;
    rd_req    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cop_ready = cop_valid;
        req_ready = !cop_valid && !branch_flush;
        if (req_valid && !cop_valid && !branch_flush) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (branch_flush) begin
          state_d = IDLE;
        end else if (hit) begin
          rsp_valid = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        rd_req = 1'b1;
        if (rd_rdy) state_d = REFILL;
      end
      REFILL: begin
        // a flushed refill still installs, but skips the response
        if (fill_done) begin
          state_d = (drop_q || branch_flush) ? IDLE : RESP;
        end
      end
      RESP: begin
        rsp_valid = !branch_flush;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      valid_q <= '0;
      beat_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) pc_q <= req_pc;
      if (state_q == IDLE && cop_valid) begin
        valid_q[cop_index] <= 1'b0;
      end
      if (fill_done) valid_q[idx] <= 1'b1;
      if (beat_fire) begin
        beat_q <= fill_done ? '0 : beat_q + 1'b1;
      end
      if (fill_done) begin
        drop_q <= 1'b0;
      end else if ((state_q == MISS || state_q == REFILL)
                   && branch_flush) begin
        drop_q <= 1'b1;
      end
      if (fill_done) begin
        assert (beat_q == BEAT_W'(LINE_WORDS - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_done) tag_q[idx] <= pc_tag;
  end

  icache_data_ram #(
    .INDEX_W    (INDEX_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_data (
    .clk      (clk),
    .we       (beat_fire && !rst),
    .wr_index (idx),
    .wr_word  (beat_q),
    .wr_data  (ret_data),
    .rd_index (idx),
    .rd_line  (line)
  );

endmodule

// File: tb/tb_icache_responder.sv
// Directed scoreboard bench for icache_responder: misses, hits,
// conflicts, flush, invalidate and reset-during-refill.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [63:0] rsp_inst;
  logic [31:0] rsp_pc;
  logic        branch_flush;
  logic        cop_valid;
  logic [7:0]  cop_index;
  logic        cop_ready;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  icache_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_pc       (req_pc),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_inst     (rsp_inst),
    .rsp_pc       (rsp_pc),
    .branch_flush (branch_flush),
    .cop_valid    (cop_valid),
    .cop_index    (cop_index),
    .cop_ready    (cop_ready),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_rdy       (rd_rdy),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdreq_cnt = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = -1;
  int acc_cyc = 0;
  int fill_cyc = 0;
  int snap;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc,
                              input logic [31:0] base);
    exp_t r;
    logic [31:0] lo;
    lo = base + (pc[3] ? 32'd2 : 32'd0);
    r.pc = pc;
    r.inst = {lo + 32'd1, lo};
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req) rdreq_cnt++;
      if (rsp_valid) begin
        last_rsp_cyc = cyc;
        rsp_cnt++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_pc", 64'(rsp_pc), 64'(e.pc));
          check("rsp_inst", rsp_inst, e.inst);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] pc);
    logic got;
    got = 1'b0;
    req_valid = 1'b1;
    req_pc = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    check("req_accept", 64'(got), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_miss(input logic [31:0] addr);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_req) begin
        got = 1'b1;
        break;
      end
    end
    check("rd_req_seen", 64'(got), 64'd1);
    check("rd_addr", 64'(rd_addr), 64'(addr));
    step();
  endtask

  task automatic send_line(input logic [31:0] base, input int flush_k,
                           input int rst_k);
    for (int k = 0; k < 4; k++) begin
      ret_valid = 1'b1;
      ret_data = base + 32'(k);
      ret_last = (k == 3);
      branch_flush = (k == flush_k);
      rst = (k == rst_k);
      if (k == 3) fill_cyc = cyc;
      step();
    end
    ret_valid = 1'b0;
    ret_last = 1'b0;
    branch_flush = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 64'(sb.size()), 64'd0);
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_pc = '0;
    branch_flush = 1'b0;
    cop_valid = 1'b0;
    cop_index = '0;
    rd_rdy = 1'b1;
    ret_valid = 1'b0;
    ret_last = 1'b0;
    ret_data = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_cop_ready", 64'(cop_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd1);
    step();

    // request together with branch_flush is refused
    req_valid = 1'b1;
    req_pc = 32'h1C00_0000;
    branch_flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_req", 64'(req_ready), 64'd0);
    step();
    req_valid = 1'b0;
    branch_flush = 1'b0;
    step();

    // cold miss
    sb.push_back(mk(32'h1C00_0008, 32'hA0));
    do_req(32'h1C00_0008);
    wait_miss(32'h1C00_0000);
    send_line(32'hA0, -1, -1);
    wait_drain();
    check("miss_latency", 64'(last_rsp_cyc), 64'(fill_cyc + 1));

    // hit
    snap = rdreq_cnt;
    sb.push_back(mk(32'h1C00_0000, 32'hA0));
    do_req(32'h1C00_0000);
    wait_drain();
    check("hit_latency", 64'(last_rsp_cyc), 64'(acc_cyc + 1));
    check("hit_no_rd_req", 64'(rdreq_cnt), 64'(snap));

    // conflict on index 0
    sb.push_back(mk(32'h1C00_1000, 32'hB0));
    do_req(32'h1C00_1000);
    wait_miss(32'h1C00_1000);
    send_line(32'hB0, -1, -1);
    wait_drain();
    sb.push_back(mk(32'h1C00_0000, 32'hA0));
    do_req(32'h1C00_0000);
    wait_miss(32'h1C00_0000);
    send_line(32'hA0, -1, -1);
    wait_drain();

    // flush during refill: line installed, no response
    snap = rsp_cnt;
    do_req(32'h1C00_0010);
    wait_miss(32'h1C00_0010);
    send_line(32'hC0, 1, -1);
    repeat (4) step();
    check("flush_no_rsp", 64'(rsp_cnt), 64'(snap));
    snap = rdreq_cnt;
    sb.push_back(mk(32'h1C00_0018, 32'hC0));
    do_req(32'h1C00_0018);
    wait_drain();
    check("flush_hit_latency", 64'(last_rsp_cyc), 64'(acc_cyc + 1));
    check("flush_hit_no_rd", 64'(rdreq_cnt), 64'(snap));

    // invalidate index 0; cop wins over a concurrent request
    cop_valid = 1'b1;
    cop_index = 8'd0;
    req_valid = 1'b1;
    req_pc = 32'h1C00_0000;
    @(negedge clk);
    check("cop_ready", 64'(cop_ready), 64'd1);
    check("cop_prio", 64'(req_ready), 64'd0);
    step();
    cop_valid = 1'b0;
    req_valid = 1'b0;
    step();
    sb.push_back(mk(32'h1C00_0000, 32'hA0));
    do_req(32'h1C00_0000);
    wait_miss(32'h1C00_0000);
    send_line(32'hA0, -1, -1);
    wait_drain();

    // cop outside IDLE, then reset at beat 2
    snap = rsp_cnt;
    do_req(32'h1C00_0020);
    wait_miss(32'h1C00_0020);
    cop_valid = 1'b1;
    cop_index = 8'd5;
    @(negedge clk);
    check("cop_busy", 64'(cop_ready), 64'd0);
    step();
    cop_valid = 1'b0;
    send_line(32'hD0, -1, 2);
    repeat (4) step();
    check("rst_no_rsp", 64'(rsp_cnt), 64'(snap));
    sb.push_back(mk(32'h1C00_0020, 32'hE0));
    do_req(32'h1C00_0020);
    wait_miss(32'h1C00_0020);
    send_line(32'hE0, -1, -1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
